// File: rtl/mips_lsu_if.sv
// mips_lsu_if: request/response and word-memory bus of the MIPS load/store unit.
//   req_*  : one load/store per valid/ready handshake (op, byte address, store data, old rt)
//   resp_* : one-cycle completion pulse with load data and 2-bit error code; busy = ~req_ready
//   mem_*  : word memory port, mem_req held until mem_ack, mem_rdata valid with mem_ack
// Modports: master = pipeline/memory side, slave = the LSU.
interface mips_lsu_if #(
   parameter int unsigned ADDR_W = 21
) ();
   logic              req_valid;
   logic              req_ready;
   logic [5:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [31:0]       req_rt_old;
   logic              resp_valid;
   logic [31:0]       resp_data;
   logic [1:0]        resp_err;
   logic              busy;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, req_rt_old, mem_ack, mem_rdata,
      input  req_ready, resp_valid, resp_data, resp_err, busy,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, req_rt_old, mem_ack, mem_rdata,
      output req_ready, resp_valid, resp_data, resp_err, busy,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/mips_lsu.sv
// mips_lsu: multi-cycle MIPS load/store unit (LB/LH/LWL/LW/LBU/LHU/LWR/SB/SH/SW).
// Little-endian lanes; FSM Idle -> Mem -> Resp -> Idle. Misaligned or illegal requests
// skip the memory access and respond one cycle after acceptance.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : mips_lsu_if.slave (request, response, busy and word-memory signals)
// Parameters: ADDR_W byte-address width; TIMEOUT max MEM cycles without mem_ack.
// Optional feature: define MIPS_LSU_TIMEOUT_EN to abort a MEM phase after TIMEOUT
// cycles with resp_err = 2'b11; otherwise MEM waits for mem_ack indefinitely.
module mips_lsu #(
   parameter int unsigned ADDR_W  = 21,
   parameter int unsigned TIMEOUT = 64
) (
   input logic       clk,
   input logic       reset,
   mips_lsu_if.slave bus
);

   localparam logic [5:0] OpLb  = 6'h20;
   localparam logic [5:0] OpLh  = 6'h21;
   localparam logic [5:0] OpLwl = 6'h22;
   localparam logic [5:0] OpLw  = 6'h23;
   localparam logic [5:0] OpLbu = 6'h24;
   localparam logic [5:0] OpLhu = 6'h25;
   localparam logic [5:0] OpLwr = 6'h26;
   localparam logic [5:0] OpSb  = 6'h28;
   localparam logic [5:0] OpSh  = 6'h29;
   localparam logic [5:0] OpSw  = 6'h2B;

   localparam logic [1:0] ErrOk       = 2'b00;
   localparam logic [1:0] ErrMisalign = 2'b01;
   localparam logic [1:0] ErrIllegal  = 2'b10;

   if (TIMEOUT < 1) begin : g_timeout_check
      $error("mips_lsu: TIMEOUT must be >= 1");
   end

   typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

   state_e              state_q, state_d;
   logic [5:0]          op_q, op_d;
   logic [1:0]          off_q, off_d;
   logic [31:0]         rt_old_q, rt_old_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-3:0]   mem_addr_q, mem_addr_d;
   logic [3:0]          mem_be_q, mem_be_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic                resp_valid_q, resp_valid_d;
   logic [31:0]         resp_data_q, resp_data_d;
   logic [1:0]          resp_err_q, resp_err_d;

`ifdef MIPS_LSU_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [1:0]  ErrTimeout = 2'b11;
   logic [CntW-1:0] cnt_q, cnt_d;
`endif

   // Request decode, evaluated on the raw request while Idle.
   logic        req_load, req_store, req_illegal, req_misaligned;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;

   always_comb begin
      req_load       = 1'b0;
      req_store      = 1'b0;
      req_misaligned = 1'b0;
      st_be          = 4'b1111;
      st_wdata       = bus.req_wdata;
      case (bus.req_op)
         OpLb, OpLbu, OpLwl, OpLwr: req_load = 1'b1;
         OpLh, OpLhu: begin
            req_load       = 1'b1;
            req_misaligned = bus.req_addr[0];
         end
         OpLw: begin
            req_load       = 1'b1;
            req_misaligned = |bus.req_addr[1:0];
         end
         OpSb: begin
            req_store = 1'b1;
            st_be     = 4'b0001 << bus.req_addr[1:0];
            st_wdata  = {4{bus.req_wdata[7:0]}};
         end
         OpSh: begin
            req_store      = 1'b1;
            req_misaligned = bus.req_addr[0];
            st_be          = 4'b0011 << bus.req_addr[1:0];
            st_wdata       = {2{bus.req_wdata[15:0]}};
         end
         OpSw: begin
            req_store      = 1'b1;
            req_misaligned = |bus.req_addr[1:0];
         end
         default: ;
      endcase
      req_illegal = ~(req_load | req_store);
   end

   // Load alignment/extension/merge from the word returned with mem_ack.
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [4:0]  lwl_sh, lwr_sh;
   logic [31:0] load_data;

   always_comb begin
      lane_b    = bus.mem_rdata[{off_q, 3'b000} +: 8];
      lane_h    = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];
      lwl_sh    = {~off_q, 3'b000};  // 8*(3-k): rdata low bytes move to the top
      lwr_sh    = {off_q, 3'b000};   // 8*k: rdata high bytes move to the bottom
      load_data = bus.mem_rdata;
      case (op_q)
         OpLb:    load_data = {{24{lane_b[7]}}, lane_b};
         OpLbu:   load_data = {24'b0, lane_b};
         OpLh:    load_data = {{16{lane_h[15]}}, lane_h};
         OpLhu:   load_data = {16'b0, lane_h};
         OpLwl:   load_data = (bus.mem_rdata << lwl_sh) |
                              (rt_old_q & ~(32'hFFFF_FFFF << lwl_sh));
         OpLwr:   load_data = (bus.mem_rdata >> lwr_sh) |
                              (rt_old_q & ~(32'hFFFF_FFFF >> lwr_sh));
         default: load_data = bus.mem_rdata;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      off_d        = off_q;
      rt_old_d     = rt_old_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
`ifdef MIPS_LSU_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif
      case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               if (req_illegal || req_misaligned) begin
                  state_d      = StResp;
                  resp_valid_d = 1'b1;
                  resp_data_d  = 32'b0;
                  resp_err_d   = req_illegal ? ErrIllegal : ErrMisalign;
               end else begin
                  state_d     = StMem;
                  op_d        = bus.req_op;
                  off_d       = bus.req_addr[1:0];
                  rt_old_d    = bus.req_rt_old;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_store;
                  mem_addr_d  = bus.req_addr[ADDR_W-1:2];
                  mem_be_d    = req_store ? st_be : 4'b1111;
                  mem_wdata_d = req_store ? st_wdata : 32'b0;
`ifdef MIPS_LSU_TIMEOUT_EN
                  cnt_d       = '0;
`endif
               end
            end
         end
         StMem: begin
            if (bus.mem_ack) begin
               state_d      = StResp;
               mem_req_d    = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = ErrOk;
               resp_data_d  = mem_we_q ? 32'b0 : load_data;
            end
`ifdef MIPS_LSU_TIMEOUT_EN
            else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               state_d      = StResp;
               mem_req_d    = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = ErrTimeout;
               resp_data_d  = 32'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`else
            // No timeout: keep waiting for mem_ack.
`endif
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         op_q         <= 6'b0;
         off_q        <= 2'b0;
         rt_old_q     <= 32'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_be_q     <= 4'b0;
         mem_wdata_q  <= 32'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 32'b0;
         resp_err_q   <= 2'b0;
`ifdef MIPS_LSU_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         off_q        <= off_d;
         rt_old_q     <= rt_old_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
`ifdef MIPS_LSU_TIMEOUT_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   assign bus.req_ready  = (state_q == StIdle);
   assign bus.busy       = (state_q != StIdle);
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_be     = mem_be_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mips_lsu.sv
// tb_mips_lsu: directed plus randomized check of mips_lsu against a byte-level model.
module tb_mips_lsu;
   localparam int unsigned AW = 21;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mips_lsu_if #(.ADDR_W(AW)) bus ();
   mips_lsu #(.ADDR_W(AW), .TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: MIPS load/store semantics worked out byte by byte.
   function automatic void model(input logic [5:0] op, input logic [AW-1:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rt,
                                 input logic [31:0] rd, output logic [1:0] err,
                                 output logic [31:0] data, output logic st,
                                 output logic [3:0] be, output logic [31:0] wdat);
      int k;
      int v;
      logic [7:0] mb [4];
      logic [7:0] res [4];
      k = int'(addr[1:0]);
      for (int i = 0; i < 4; i++) begin
         mb[i]  = rd[8*i +: 8];
         res[i] = rt[8*i +: 8];
      end
      err = 2'd0; data = 32'd0; st = 1'b0; be = 4'hF; wdat = 32'd0;
      case (op)
         6'h20, 6'h24: begin
            v = int'(mb[k]);
            if (op == 6'h20 && v >= 128) v -= 256;
            data = 32'(v);
         end
         6'h21, 6'h25: begin
            if (k % 2 != 0) err = 2'd1;
            else begin
               v = int'(mb[k]) + 256 * int'(mb[k+1]);
               if (op == 6'h21 && v >= 32768) v -= 65536;
               data = 32'(v);
            end
         end
         6'h23: if (k != 0) err = 2'd1; else data = rd;
         6'h22: begin
            for (int i = 0; i <= k; i++) res[3-k+i] = mb[i];
            data = {res[3], res[2], res[1], res[0]};
         end
         6'h26: begin
            for (int i = 0; i <= 3 - k; i++) res[i] = mb[k+i];
            data = {res[3], res[2], res[1], res[0]};
         end
         6'h28: begin
            st = 1'b1; be = 4'h0; be[k] = 1'b1;
            for (int j = 0; j < 4; j++) wdat[8*j +: 8] = wd[7:0];
         end
         6'h29: begin
            st = 1'b1;
            if (k % 2 != 0) err = 2'd1;
            else begin
               be = 4'h0; be[k] = 1'b1; be[k+1] = 1'b1;
               for (int j = 0; j < 4; j++) wdat[8*j +: 8] = wd[8*(j%2) +: 8];
            end
         end
         6'h2B: begin
            st = 1'b1;
            if (k != 0) err = 2'd1; else wdat = wd;
         end
         default: err = 2'd2;
      endcase
   endfunction

   task automatic check_idle_reset(input string tag);
      check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
      check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
      check({tag, "_mem_be"}, 32'(bus.mem_be), 32'd0);
      check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
      check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
      check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
      check({tag, "_resp_data"}, bus.resp_data, 32'd0);
      check({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
      check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   // One transaction; called #1 after a rising edge (cycle 0 = accept cycle).
   task automatic do_op(input logic [5:0] op, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [31:0] rt, input logic [31:0] rd, input int delay);
      logic [1:0]  e_err;
      logic [31:0] e_data, e_wdat;
      logic        e_st;
      logic [3:0]  e_be;
      model(op, addr, wd, rt, rd, e_err, e_data, e_st, e_be, e_wdat);
      bus.req_valid  = 1'b1;
      bus.req_op     = op;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      bus.req_rt_old = rt;
      check("accept_ready", 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = 1'b0;
      if (e_err != 2'd0) begin
         check("err_valid", 32'(bus.resp_valid), 32'd1);
         check("err_code", 32'(bus.resp_err), 32'(e_err));
         check("err_data", bus.resp_data, 32'd0);
         check("err_no_mem", 32'(bus.mem_req), 32'd0);
         tick();
         check("err_pulse_end", 32'(bus.resp_valid), 32'd0);
         check("err_back_idle", 32'(bus.req_ready), 32'd1);
         return;
      end
      check("mem_req", 32'(bus.mem_req), 32'd1);
      check("mem_we", 32'(bus.mem_we), 32'(e_st));
      check("mem_addr", 32'(bus.mem_addr), 32'(addr >> 2));
      check("mem_be", 32'(bus.mem_be), 32'(e_be));
      if (e_st) check("mem_wdata", bus.mem_wdata, e_wdat);
      check("busy", 32'(bus.busy), 32'd1);
      check("not_ready", 32'(bus.req_ready), 32'd0);
      for (int i = 0; i < delay; i++) begin
         // Requests presented outside Idle must be ignored.
         bus.req_valid = 1'b1;
         bus.req_op    = 6'h23;
         bus.req_addr  = AW'($urandom);
         tick();
         check("hold_req", 32'(bus.mem_req), 32'd1);
         check("hold_addr", 32'(bus.mem_addr), 32'(addr >> 2));
         check("no_early_resp", 32'(bus.resp_valid), 32'd0);
      end
      bus.req_valid = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rd;
      tick();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      check("resp_valid", 32'(bus.resp_valid), 32'd1);
      check("resp_err", 32'(bus.resp_err), 32'd0);
      check("resp_data", bus.resp_data, e_data);
      check("req_dropped", 32'(bus.mem_req), 32'd0);
      tick();
      check("resp_pulse_end", 32'(bus.resp_valid), 32'd0);
      check("back_idle", 32'(bus.req_ready), 32'd1);
   endtask

   logic [5:0] ops [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h28, 6'h29, 6'h2B};

   initial begin
      logic [5:0] op;
      bus.req_valid  = 1'b0;
      bus.req_op     = 6'h0;
      bus.req_addr   = '0;
      bus.req_wdata  = 32'h0;
      bus.req_rt_old = 32'h0;
      bus.mem_ack    = 1'b0;
      bus.mem_rdata  = 32'h0;
      reset = 1'b1;
      tick();
      tick();
      check_idle_reset("reset");
      reset = 1'b0;
      tick();

      // Directed cases.
      do_op(6'h23, 21'h100, 32'h0, 32'h0, 32'hDEADBEEF, 0);
      do_op(6'h20, 21'h103, 32'h0, 32'h0, 32'h80FF_0000, 1);
      do_op(6'h24, 21'h103, 32'h0, 32'h0, 32'h80FF_0000, 0);
      do_op(6'h21, 21'h102, 32'h0, 32'h0, 32'h80FF_0000, 2);
      do_op(6'h28, 21'h201, 32'h12345678, 32'h0, 32'h0, 0);
      do_op(6'h29, 21'h202, 32'h12345678, 32'h0, 32'h0, 1);
      do_op(6'h23, 21'h101, 32'h0, 32'h0, 32'h0, 0);
      do_op(6'h00, 21'h100, 32'h0, 32'h0, 32'h0, 0);
      do_op(6'h22, 21'h101, 32'h0, 32'h11223344, 32'hAABBCCDD, 0);
      do_op(6'h26, 21'h101, 32'h0, 32'h11223344, 32'hAABBCCDD, 3);

      // A stray ack while idle must not produce anything.
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      check("stale_ack_resp", 32'(bus.resp_valid), 32'd0);
      check("stale_ack_req", 32'(bus.mem_req), 32'd0);
      check("stale_ack_ready", 32'(bus.req_ready), 32'd1);

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 7) == 0) op = 6'($urandom);
         else op = ops[$urandom_range(0, 9)];
         do_op(op, AW'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
      end

      // Reset in the middle of a memory access; the late ack must be dropped.
      bus.req_valid = 1'b1;
      bus.req_op    = 6'h2B;
      bus.req_addr  = 21'h404;
      bus.req_wdata = 32'hCAFEF00D;
      tick();
      bus.req_valid = 1'b0;
      check("pre_reset_req", 32'(bus.mem_req), 32'd1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle_reset("midreset");
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      check("late_ack_resp", 32'(bus.resp_valid), 32'd0);
      check("late_ack_req", 32'(bus.mem_req), 32'd0);
      tick();
      check("late_ack_resp2", 32'(bus.resp_valid), 32'd0);

`ifdef MIPS_LSU_TIMEOUT_EN
      // Ack withheld: four MEM cycles, then a timeout response.
      bus.req_valid = 1'b1;
      bus.req_op    = 6'h23;
      bus.req_addr  = 21'h300;
      tick();
      bus.req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("to_mem_req", 32'(bus.mem_req), 32'd1);
         check("to_no_resp", 32'(bus.resp_valid), 32'd0);
         tick();
      end
      check("to_resp_valid", 32'(bus.resp_valid), 32'd1);
      check("to_resp_err", 32'(bus.resp_err), 32'd3);
      check("to_resp_data", bus.resp_data, 32'd0);
      check("to_req_dropped", 32'(bus.mem_req), 32'd0);
      tick();
      check("to_pulse_end", 32'(bus.resp_valid), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
